ibexc_data_responder: RTL and testbench

Data-memory responder for the CHERIoT Ibex data port. It is the memory side of the core's req/gnt/rvalid data interface. It holds tagged 33-bit words (bit 32 is the capability tag), enforces tag-clearing on non-capability writes, checks write-data integrity and returns in-order responses after a programmable delay. It is used in simulation and FPGA top levels in place of the SRAM/bus fabric behind `data_*`.

---
 rtl/ibexc_data_responder.sv | 119 +++++++++++
 tb/tb_ibexc_data_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibexc_data_responder.sv
// Data-memory responder for the CHERIoT Ibex data port: tagged 33-bit storage behind a
// req/gnt/rvalid interface with write-integrity checking and a fixed-latency response pipe.
module ibexc_data_responder #(
    parameter int unsigned DataWidth      = 33,
    parameter logic [31:0] MemBase        = 32'h2000_0000,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RespDelay      = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_req_i,
    input  logic                 data_is_cap_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    input  logic [6:0]           data_wdata_intg_i,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic [6:0]           data_rdata_intg_o,
    output logic                 data_err_o,
    input  logic                 stall_i,
    output logic                 intg_err_o
);

    localparam int unsigned IdxW     = $clog2(MemWords);
    localparam logic [31:0] WinBytes = 32'(MemWords) << 2;
    localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);

    // Inverted SECDED(39,32) check bits, matching the core's integrity encoder.
    function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
        logic [6:0] c;
        c[0] = ^(d & 32'h2606_BD25);
        c[1] = ^(d & 32'hDEBA_8050);
        c[2] = ^(d & 32'h413D_89AA);
        c[3] = ^(d & 32'h3123_4ED1);
        c[4] = ^(d & 32'hC2C1_323B);
        c[5] = ^(d & 32'h2DCC_624C);
        c[6] = ^(d & 32'h9850_5586);
        return c ^ 7'h2A;
    endfunction

    logic [DataWidth-1:0] mem_q [MemWords];

    logic [2:0]           cnt_q, cnt_d;
    logic [RespDelay-1:0] valid_q, err_q;
    logic [DataWidth-1:0] rdata_q [RespDelay];
    logic                 intg_err_q;

    logic [31:0]          offset;
    logic [IdxW-1:0]      idx;
    logic                 in_range, cap_be_err, intg_mismatch, acc_err, mem_we;
    logic [DataWidth-1:0] rd_word, wr_word, stage_rdata;

    always_comb begin
        offset        = data_addr_i - MemBase;
        // Addresses below MemBase wrap to large offsets and fail this compare too.
        in_range      = offset < WinBytes;
        idx           = offset[IdxW+1:2];
        cap_be_err    = data_is_cap_i & (data_be_i != 4'hF);
        intg_mismatch = data_we_i &
                        (data_wdata_intg_i != secded_inv_enc(data_wdata_i[31:0]));
        acc_err       = ~in_range | cap_be_err | intg_mismatch;

        data_gnt_o    = data_req_i & ~stall_i & (cnt_q < MaxOut);
        mem_we        = data_gnt_o & data_we_i & ~acc_err;

        rd_word = mem_q[idx];
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
                wr_word[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
        // Any non-capability store, even with no bytes enabled, strips the tag.
        wr_word[DataWidth-1] = data_is_cap_i & data_wdata_i[DataWidth-1];

        stage_rdata = (acc_err | data_we_i) ? '0 : rd_word;
        cnt_d       = cnt_q + {2'b00, data_gnt_o} - {2'b00, data_rvalid_o};
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            intg_err_q <= 1'b0;
            for (int i = 0; i < RespDelay; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            valid_q[0] <= data_gnt_o;
            err_q[0]   <= data_gnt_o & acc_err;
            rdata_q[0] <= data_gnt_o ? stage_rdata : '0;
            for (int i = 1; i < RespDelay; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
            intg_err_q <= data_gnt_o & intg_mismatch;
        end
    end

    assign data_rvalid_o     = valid_q[RespDelay-1];
    assign data_err_o        = err_q[RespDelay-1];
    assign data_rdata_o      = rdata_q[RespDelay-1];
    assign data_rdata_intg_o = secded_inv_enc(data_rdata_o[31:0]);
    assign intg_err_o        = intg_err_q;

endmodule

// File: tb/tb_ibexc_data_responder.sv
// Randomised and directed bench for ibexc_data_responder against a transaction-level memory
// model with a queue of responses due at absolute cycle numbers.
module tb_ibexc_data_responder;

    localparam logic [31:0] MemBase   = 32'h2000_0000;
    localparam int unsigned MemWords  = 64;
    localparam int unsigned RespDelay = 3;
    localparam int unsigned MaxOut    = 2;

    logic        clk, rst_n;
    logic        req, is_cap, we, stall;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic [6:0]  wintg;
    logic        gnt, rvalid, err, intg_err;
    logic [32:0] rdata;
    logic [6:0]  rintg;

    ibexc_data_responder #(
        .DataWidth     (33),
        .MemBase       (MemBase),
        .MemWords      (MemWords),
        .RespDelay     (RespDelay),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .data_req_i       (req),
        .data_is_cap_i    (is_cap),
        .data_gnt_o       (gnt),
        .data_rvalid_o    (rvalid),
        .data_we_i        (we),
        .data_be_i        (be),
        .data_addr_i      (addr),
        .data_wdata_i     (wdata),
        .data_wdata_intg_i(wintg),
        .data_rdata_o     (rdata),
        .data_rdata_intg_o(rintg),
        .data_err_o       (err),
        .stall_i          (stall),
        .intg_err_o       (intg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [32:0] rdata;
        logic        err;
    } resp_t;

    int          checks, failures, cyc, out_m;
    logic [32:0] mem_m [MemWords];
    resp_t       pend [$];
    logic        intg_exp, gnt_seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Parity of each check bit over its data mask, then the inversion pattern.
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [31:0] masks [7];
        logic [6:0]  c;
        masks = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
                  32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
        for (int k = 0; k < 7; k++) c[k] = ($countones(d & masks[k]) % 2) == 1;
        return c ^ 7'h2A;
    endfunction

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic w, input logic cap, input logic [3:0] b,
                        input logic [31:0] a, input logic [32:0] wd, input logic [6:0] wi,
                        input logic st);
        logic        exp_rv, exp_gnt, e, bad_intg;
        logic [31:0] off;
        logic [32:0] rd, word;
        resp_t       rsp;
        @(negedge clk);
        req = r; we = w; is_cap = cap; be = b; addr = a; wdata = wd; wintg = wi; stall = st;
        #1;
        exp_rv = (pend.size() > 0) && (pend[0].due == cyc);
        check_eq("rvalid", rvalid, exp_rv);
        if (exp_rv) begin
            rsp = pend.pop_front();
            check_eq("rdata", rdata, rsp.rdata);
            check_eq("err", err, rsp.err);
            check_eq("rdata_intg", rintg, enc(rsp.rdata[31:0]));
        end
        check_eq("intg_err", intg_err, intg_exp);
        exp_gnt = r && !st && (out_m < MaxOut);
        check_eq("gnt", gnt, exp_gnt);
        gnt_seen = gnt;
        intg_exp = 1'b0;
        if (exp_gnt) begin
            off      = a - MemBase;
            bad_intg = w && (wi != enc(wd[31:0]));
            e        = (off >= 4 * MemWords) || (cap && b != 4'hF) || bad_intg;
            rd       = '0;
            if (!e) begin
                if (w) begin
                    word = mem_m[off >> 2];
                    for (int k = 0; k < 4; k++) if (b[k]) word[8*k +: 8] = wd[8*k +: 8];
                    word[32] = cap ? wd[32] : 1'b0;
                    mem_m[off >> 2] = word;
                end else begin
                    rd = mem_m[off >> 2];
                end
            end
            rsp.due = cyc + RespDelay; rsp.rdata = rd; rsp.err = e;
            pend.push_back(rsp);
            intg_exp = bad_intg;
        end
        out_m = out_m + int'(exp_gnt) - int'(exp_rv);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 32'h0, 33'h0, 7'h0, 0);
    endtask

    // Hold a request until it is granted (bounded).
    task automatic issue(input logic w, input logic cap, input logic [3:0] b,
                         input logic [31:0] a, input logic [32:0] wd, input logic [6:0] wi);
        int tries;
        tries = 0;
        do begin
            step(1, w, cap, b, a, wd, wi, 0);
            tries++;
        end while (!gnt_seen && tries < 20);
        if (!gnt_seen) check_eq("issue_gnt", gnt_seen, 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; req = 0; we = 0; is_cap = 0; stall = 0;
        pend.delete(); out_m = 0; intg_exp = 1'b0;
        #1;
        check_eq("rst_rvalid", rvalid, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_intg_err", intg_err, 1'b0);
        check_eq("rst_rdata", rdata, 33'h0);
        check_eq("rst_rdata_intg", rintg, enc(32'h0));
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          ncyc, ngnt;
        logic [31:0] a;
        logic [32:0] wd;
        logic [6:0]  wi;
        checks = 0; failures = 0; cyc = 0; out_m = 0; intg_exp = 1'b0; gnt_seen = 1'b0;
        rst_n = 1'b0; req = 0; we = 0; is_cap = 0; be = 0; addr = 0; wdata = 0; wintg = 0;
        stall = 0;
        do_reset(2);

        // Storage has no reset, so give every word a known value first.
        for (int i = 0; i < MemWords; i++) begin
            wd = {1'b0, $urandom};
            issue(1, 1, 4'hF, MemBase + 4 * i, wd, enc(wd[31:0]));
        end
        idle(RespDelay + 2);

        // Capability write keeps its tag; immediate read sees the committed word.
        issue(1, 1, 4'hF, MemBase + 8, 33'h1_DEAD_BEEF, enc(32'hDEAD_BEEF));
        issue(0, 0, 4'hF, MemBase + 8, 33'h0, 7'h0);
        idle(RespDelay + 1);
        // Partial non-cap write clears the tag.
        issue(1, 0, 4'b0001, MemBase + 8, 33'h0_0000_0011, enc(32'h11));
        issue(0, 0, 4'hF, MemBase + 8, 33'h0, 7'h0);
        issue(1, 0, 4'h0, MemBase + 12, 33'h1_0000_0000, enc(32'h0));
        issue(0, 1, 4'hF, MemBase + 12, 33'h0, 7'h0);
        // Out-of-range on both sides, malformed cap write, bad write integrity.
        issue(0, 0, 4'hF, MemBase + 4 * MemWords, 33'h0, 7'h0);
        issue(0, 0, 4'hF, MemBase - 4, 33'h0, 7'h0);
        issue(1, 1, 4'b0011, MemBase + 8, 33'h1_1234_5678, enc(32'h1234_5678));
        issue(0, 0, 4'hF, MemBase + 8, 33'h0, 7'h0);
        issue(1, 0, 4'hF, MemBase + 16, 33'h0_CAFE_F00D, enc(32'hCAFE_F00D) ^ 7'h01);
        issue(0, 0, 4'hF, MemBase + 16, 33'h0, 7'h0);
        idle(RespDelay + 2);

        // Six back-to-back reads from idle: grants land in cycles 0,1,4,5,8,9.
        ncyc = 0; ngnt = 0;
        while (ngnt < 6 && ncyc < 40) begin
            step(1, 0, 0, 4'hF, MemBase + 4 * ngnt, 33'h0, 7'h0, 0);
            ncyc++;
            if (gnt_seen) ngnt++;
        end
        check_eq("tput_cycles", ncyc, 10);
        idle(RespDelay + 2);

        repeat (3) step(1, 0, 0, 4'hF, MemBase, 33'h0, 7'h0, 1);

        // Reset with two reads in flight: nothing may come back afterwards.
        issue(0, 0, 4'hF, MemBase + 4, 33'h0, 7'h0);
        issue(0, 0, 4'hF, MemBase + 20, 33'h0, 7'h0);
        do_reset(2);
        idle(RespDelay + 3);
        step(1, 0, 0, 4'hF, MemBase + 8, 33'h0, 7'h0, 0);
        step(1, 0, 0, 4'hF, MemBase + 12, 33'h0, 7'h0, 0);
        idle(RespDelay + 2);

        for (int i = 0; i < 600; i++) begin
            a = MemBase + 4 * $urandom_range(0, MemWords - 1) + $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0)
                a = ($urandom_range(0, 1) == 0) ? MemBase + 4 * MemWords + 4 * $urandom_range(0, 7)
                                                : MemBase - 4 * $urandom_range(1, 8);
            wd = {1'($urandom), $urandom};
            wi = enc(wd[31:0]);
            if ($urandom_range(0, 19) == 0) wi = wi ^ 7'(1 << $urandom_range(0, 6));
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, a, wd, wi,
                 $urandom_range(0, 9) == 0);
        end
        idle(RespDelay + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
